// File: rtl/integral_image_builder_if.sv
// Pixel stream in, integral-image write port and frame status out.
interface integral_image_builder_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [3:0]  pix_data;
    logic        ii_wr_en;
    logic [14:0] ii_wr_addr;
    logic [19:0] ii_wr_data;
    logic        busy;
    logic        frame_done;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  ii_wr_en, ii_wr_addr, ii_wr_data, busy, frame_done
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output ii_wr_en, ii_wr_addr, ii_wr_data, busy, frame_done
    );
endinterface

// File: rtl/integral_image_builder.sv
// Streams a raster-order frame and emits ii(x,y) = running row sum + ii(x,y-1)
// from a one-row delay line, one registered write per accepted pixel.
module integral_image_builder #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120
) (
    input logic                     clk_vga,
    input logic                     rst_n,
    integral_image_builder_if.slave bus
);
    localparam int CW = (II_WIDTH  > 1) ? $clog2(II_WIDTH)  : 1;
    localparam int RW = (II_HEIGHT > 1) ? $clog2(II_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(II_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(II_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t      state_reg, state_next;
    logic        frame_done_reg, frame_done_next;
    logic [CW-1:0] col_ctr_reg;
    logic [RW-1:0] row_ctr_reg;
    logic [19:0] row_sum_reg;
    logic [14:0] pix_addr_reg;
    logic        ii_wr_en_reg;
    logic [14:0] ii_wr_addr_reg;
    logic [19:0] ii_wr_data_reg;

    logic [19:0] line_buf [II_WIDTH];

    logic          start, accept, col_last, row_last, frame_last;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [14:0]   cur_addr;
    logic [19:0]   row_sum_next, above, ii_value;

    // A start-of-frame pixel is processed as (0,0) from IDLE or ACCUM alike,
    // which is what makes a mid-frame sof an abort/restart.
    always_comb begin
        start        = bus.pix_valid & bus.pix_sof & (state_reg != DONE);
        accept       = bus.pix_valid & ((state_reg == ACCUM) | start);
        cur_col      = start ? '0 : col_ctr_reg;
        cur_row      = start ? '0 : row_ctr_reg;
        cur_addr     = start ? '0 : pix_addr_reg;
        col_last     = (cur_col == COL_LAST);
        row_last     = (cur_row == ROW_LAST);
        frame_last   = accept & col_last & row_last;
        row_sum_next = (cur_col == '0) ? {16'd0, bus.pix_data}
                                       : row_sum_reg + 20'(bus.pix_data);
        // Row 0 never looks at the delay line, so stale contents are harmless.
        above        = (cur_row == '0) ? 20'd0 : line_buf[cur_col];
        ii_value     = row_sum_next + above;
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            IDLE, ACCUM: begin
                if (frame_last)
                    state_next = DONE;
                else if (start)
                    state_next = ACCUM;
            end
            DONE: begin
                state_next      = IDLE;
                frame_done_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            col_ctr_reg    <= '0;
            row_ctr_reg    <= '0;
            row_sum_reg    <= '0;
            pix_addr_reg   <= '0;
            ii_wr_en_reg   <= 1'b0;
            ii_wr_addr_reg <= '0;
            ii_wr_data_reg <= '0;
        end else if (accept) begin
            ii_wr_en_reg   <= 1'b1;
            ii_wr_addr_reg <= cur_addr;
            ii_wr_data_reg <= ii_value;
            row_sum_reg    <= row_sum_next;
            pix_addr_reg   <= frame_last ? 15'd0 : cur_addr + 15'd1;
            if (col_last) begin
                col_ctr_reg <= '0;
                row_ctr_reg <= row_last ? '0 : cur_row + 1'b1;
            end else begin
                col_ctr_reg <= cur_col + 1'b1;
                row_ctr_reg <= cur_row;
            end
        end else begin
            ii_wr_en_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (accept)
            line_buf[cur_col] <= ii_value;
    end

    assign bus.ii_wr_en   = ii_wr_en_reg;
    assign bus.ii_wr_addr = ii_wr_addr_reg;
    assign bus.ii_wr_data = ii_wr_data_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_integral_image_builder.sv
// Directed frames (uniform, maximum, gradient with gaps, abort, reset) checked
// against closed-form integral-image values.
module tb_integral_image_builder;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic clk_vga = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_vga = ~clk_vga;

    integral_image_builder_if bus ();

    integral_image_builder #(.II_WIDTH(W), .II_HEIGHT(H)) dut (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned obs [NPIX];
    int unsigned wr_count = 0, data_err = 0, seq_err = 0, fd_count = 0;
    int unsigned exp_addr = 0, cyc = 0, last_wr_cyc = 0, fd_cyc = 0;
    int unsigned rs_addr = 32'hFFFF_FFFF, rs_data = 32'hFFFF_FFFF;
    bit          restart_pending = 1'b0;
    int          mdl_mode = 0, mdl_v = 0, mdl_p00 = 0;
    int unsigned mon_a, mon_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // mode 0: every pixel = mdl_v; mode 1: pixel = x mod 16. (0,0) holds mdl_p00.
    function automatic int unsigned exp_ii(input int x, input int y);
        int rp = 0;
        for (int i = 0; i <= x; i++)
            rp += (mdl_mode != 0) ? (i % 16) : mdl_v;
        return int'(((y + 1) * rp + mdl_p00 - ((mdl_mode != 0) ? 0 : mdl_v)) & 32'hF_FFFF);
    endfunction

    always @(negedge clk_vga) begin
        cyc++;
        if (bus.ii_wr_en) begin
            mon_a = 32'(bus.ii_wr_addr);
            mon_d = 32'(bus.ii_wr_data);
            if (restart_pending) begin
                rs_addr = mon_a;
                rs_data = mon_d;
                restart_pending = 1'b0;
                if (mon_a != 0) seq_err++;
            end else if (mon_a != exp_addr) begin
                seq_err++;
            end
            exp_addr = (mon_a + 1) % NPIX;
            wr_count++;
            if (mon_a < NPIX) begin
                obs[mon_a] = mon_d;
                if (mon_d != exp_ii(int'(mon_a % W), int'(mon_a / W))) data_err++;
                if (mon_a == NPIX - 1) last_wr_cyc = cyc;
            end else begin
                seq_err++;
            end
        end
        if (bus.frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
    end

    task automatic idle_cycle();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        @(posedge clk_vga); #1;
    endtask

    task automatic send_pix(input int d, input bit sof, input int gap_pct);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct)
            repeat ($urandom_range(3, 1)) idle_cycle();
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = 4'(d);
        @(posedge clk_vga); #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        if (sof) begin
            restart_pending = 1'b1;
            mdl_p00 = d;
        end
    endtask

    task automatic send_frame(input int mode, input int v, input int gap_pct,
                              input int first, input int last);
        mdl_mode = mode;
        mdl_v    = v;
        for (int i = first; i <= last; i++)
            send_pix((mode != 0) ? ((i % W) % 16) : v, i == 0, gap_pct);
    endtask

    task automatic clear_stats();
        wr_count = 0;
        data_err = 0;
        seq_err  = 0;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 4'd0;
        repeat (3) @(posedge clk_vga);
        #1;
        check("rst_wr_en", 32'(bus.ii_wr_en), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        rst_n = 1'b1;
        idle_cycle();

        // Pixels without sof in IDLE are dropped.
        clear_stats();
        for (int i = 0; i < 10; i++) send_pix(1, 1'b0, 0);
        idle_cycle();
        check("idle_no_writes", wr_count, 0);
        check("idle_busy", 32'(bus.busy), 0);

        // Uniform frame of ones.
        clear_stats();
        send_frame(0, 1, 0, 0, 99);
        check("accum_busy", 32'(bus.busy), 1);
        send_frame(0, 1, 0, 100, NPIX - 1);
        check("done_busy", 32'(bus.busy), 1);
        repeat (4) idle_cycle();
        check("f1_writes", wr_count, NPIX);
        check("f1_data_err", data_err, 0);
        check("f1_seq_err", seq_err, 0);
        check("f1_a0", obs[0], 1);
        check("f1_a159", obs[159], 160);
        check("f1_a160", obs[160], 2);
        check("f1_a319", obs[319], 320);
        check("f1_a19199", obs[19199], 19200);
        check("f1_frame_done_cnt", fd_count, 1);
        check("f1_done_latency", fd_cyc - last_wr_cyc, 1);
        check("f1_idle_busy", 32'(bus.busy), 0);

        // Maximum-value frame.
        clear_stats();
        send_frame(0, 15, 0, 0, NPIX - 1);
        repeat (4) idle_cycle();
        check("f2_writes", wr_count, NPIX);
        check("f2_data_err", data_err, 0);
        check("f2_a19199", obs[19199], 288000);
        check("f2_frame_done_cnt", fd_count, 2);

        // Gradient with gaps, aborted at (37,5) by sof carrying pixel value 5.
        clear_stats();
        send_frame(1, 0, 20, 0, 5 * W + 37 - 1);
        send_pix(5, 1'b1, 0);
        idle_cycle();
        check("abort_addr", rs_addr, 0);
        check("abort_data", rs_data, 5);
        check("abort_no_done", fd_count, 2);
        send_frame(1, 0, 20, 1, NPIX - 1);
        repeat (4) idle_cycle();
        check("f3_writes", wr_count, 5 * W + 37 + NPIX);
        check("f3_data_err", data_err, 0);
        check("f3_seq_err", seq_err, 0);
        check("f3_a1", obs[1], 6);
        check("f3_a19199", obs[19199], 144005);
        check("f3_frame_done_cnt", fd_count, 3);

        // Reset asserted at pixel (80,60).
        clear_stats();
        send_frame(0, 2, 0, 0, 60 * W + 80 - 1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 4'd2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(bus.ii_wr_en), 0);
        check("mid_rst_addr", 32'(bus.ii_wr_addr), 0);
        check("mid_rst_data", 32'(bus.ii_wr_data), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_frame_done", 32'(bus.frame_done), 0);
        @(posedge clk_vga); #1;
        @(posedge clk_vga); #1;
        rst_n = 1'b1;
        bus.pix_valid = 1'b0;
        restart_pending = 1'b0;
        clear_stats();
        for (int i = 0; i < 20; i++) send_pix(3, 1'b0, 0);
        idle_cycle();
        check("post_rst_no_writes", wr_count, 0);
        check("post_rst_busy", 32'(bus.busy), 0);
        send_frame(0, 3, 0, 0, 399);
        repeat (2) idle_cycle();
        check("f4_writes", wr_count, 400);
        check("f4_data_err", data_err, 0);
        check("f4_seq_err", seq_err, 0);
        check("f4_a0", obs[0], 3);
        check("f4_a399", obs[399], 720);
        check("f4_no_done", fd_count, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
